// File: rtl/bs_result_uart_tx.sv
// rtl/bs_result_uart_tx.sv - round-robin result collector, FIFO and 8N1 UART frame sender (optional checksum byte: RESULT_FRAME_CHECKSUM_EN)
module bs_result_uart_tx #(
    parameter int BSMODS       = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [BSMODS-1:0]             res_valid,
    input  logic [BSMODS*64-1:0]          res_data,
    output logic [BSMODS-1:0]             res_ack,
    output logic                          TX,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW   = (BSMODS > 1) ? $clog2(BSMODS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef RESULT_FRAME_CHECKSUM_EN
    localparam int FRAME_BYTES = 9;
`else
    localparam int FRAME_BYTES = 8;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   rr_ptr, grant_idx, cand;
    logic            found, push, pop, full, empty, can_push;
    logic [63:0]     push_data;
    logic [63:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [3:0]      byte_idx;
    logic [63:0]     frame;
    logic [7:0]      cur_byte;
    logic            tick, last_byte;

    assign full     = (count == CNTW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = (state == IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO may still accept a push.
    assign can_push = !full || pop;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < BSMODS; i++) begin
            cand = PW'((int'(rr_ptr) + i) % BSMODS);
            if (!found && res_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        push_data = '0;
        for (int k = 0; k < BSMODS; k++) begin
            if (grant_idx == PW'(k)) push_data = res_data[k*64 +: 64];
        end
    end

    assign push    = found && can_push && !reset;
    assign res_ack = push ? (BSMODS'(1) << grant_idx) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (int'(grant_idx) == BSMODS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign tick      = (bit_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_byte = (byte_idx == 4'(FRAME_BYTES - 1));

`ifdef RESULT_FRAME_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = '0;
        for (int k = 0; k < 8; k++) csum = csum ^ frame[k*8 +: 8];
    end
    assign cur_byte = byte_idx[3] ? csum : frame[{byte_idx[2:0], 3'b000} +: 8];
`else
    assign cur_byte = frame[{byte_idx[2:0], 3'b000} +: 8];
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!empty)                  state_next = START;
            START: if (tick)                    state_next = DATA;
            DATA:  if (tick && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (tick)                    state_next = last_byte ? IDLE : START;
            default:                            state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame    <= '0;
        end else begin
            if (state == IDLE) bit_cnt <= '0;
            else               bit_cnt <= tick ? '0 : bit_cnt + 1'b1;
            if (pop) begin
                frame    <= mem[rd_ptr];
                byte_idx <= '0;
                bit_idx  <= '0;
            end
            if (state == DATA && tick) bit_idx  <= bit_idx + 1'b1;
            if (state == STOP && tick) byte_idx <= byte_idx + 1'b1;
        end
    end

    always_comb begin
        TX = 1'b1;
        case (state)
            START:   TX = 1'b0;
            DATA:    TX = cur_byte[bit_idx];
            default: TX = 1'b1;
        endcase
    end

    assign tx_busy    = (state != IDLE) || !empty;
    assign fifo_count = count;

endmodule
